// File: rtl/tick_timer_if.sv
// Control/status bundle between the core and the tick timer.
// The master modport drives the controls; the slave modport is the timer itself.
interface tick_timer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             stop;
  logic             periodic;
  logic [WIDTH-1:0] period;
  logic             irq_clear;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             match;
  logic             irq;

  modport master (
    output start, stop, periodic, period, irq_clear,
    input  count, running, match, irq
  );

  modport slave (
    input  start, stop, periodic, period, irq_clear,
    output count, running, match, irq
  );
endinterface

// File: rtl/tick_timer.sv
// Interval timer counting synchronized rising edges of the divided clock.
// Supports one-shot and periodic modes with a registered match pulse and sticky irq.
module tick_timer #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         tick_clk_in,
  tick_timer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   sync_out;
  logic                   tick;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             periodic_q, periodic_d;
  logic             match_q, match_d;
  logic             irq_q, irq_d;
  logic             last_tick;

  // tick_clk_in is asynchronous to clk, so it is only ever used after the synchronizer.
  assign sync_out = sync_q[SYNC_STAGES-1];
  assign tick     = sync_out & ~edge_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_clk_in};
      edge_q <= sync_out;
    end
  end

  // A zero period disables the compare so the counter free-runs.
  assign last_tick = (period_q != '0) && (count_q == period_q - WIDTH'(1));

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    period_d   = period_q;
    periodic_d = periodic_q;
    match_d    = 1'b0;
    irq_d      = irq_q & ~bus.irq_clear;

    if (bus.stop) begin
      state_d = StIdle;
    end else if (bus.start) begin
      state_d    = StRun;
      count_d    = '0;
      period_d   = bus.period;
      periodic_d = bus.periodic;
    end else if (state_q == StRun && tick) begin
      if (last_tick) begin
        match_d = 1'b1;
        irq_d   = 1'b1;  // a set beats a coincident clear
        if (periodic_q) begin
          count_d  = '0;
          period_d = bus.period;
        end else begin
          count_d = period_q;
          state_d = StDone;
        end
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      period_q   <= '0;
      periodic_q <= 1'b0;
      match_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      period_q   <= period_d;
      periodic_q <= periodic_d;
      match_q    <= match_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.running = (state_q == StRun);
  assign bus.match   = match_q;
  assign bus.irq     = irq_q;

endmodule

// File: tb/tb_tick_timer.sv
// Scoreboard bench for tick_timer: a 32-bit instance for mode/irq behaviour and a
// 4-bit instance for counter wrap with a zero period.
module tb_tick_timer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tick_clk_in = 1'b0;

  always #5 clk = ~clk;

  tick_timer_if #(.WIDTH(32)) bus_a ();
  tick_timer_if #(.WIDTH(4))  bus_b ();

  tick_timer #(.WIDTH(32), .SYNC_STAGES(2)) dut_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick_clk_in (tick_clk_in),
    .bus         (bus_a)
  );

  tick_timer #(.WIDTH(4), .SYNC_STAGES(2)) dut_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick_clk_in (tick_clk_in),
    .bus         (bus_b)
  );

  typedef enum {MIdle, MRun, MDone} mstate_e;

  typedef struct {
    logic [31:0] cnt;
    bit          mt;
    bit          irq;
    bit          run;
    logic [3:0]  cnt_b;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  mstate_e     m_state;
  logic [31:0] m_count;
  logic [31:0] m_period;
  bit          m_periodic;
  bit          m_irq;
  int          m_matches;
  bit          b_run;
  logic [3:0]  b_count;

  int match_seen_a = 0;
  int match_seen_b = 0;

  always @(negedge clk) begin
    if (bus_a.match === 1'b1) match_seen_a++;
    if (bus_b.match === 1'b1) match_seen_b++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state    = MIdle;
    m_count    = '0;
    m_period   = '0;
    m_periodic = 1'b0;
    m_irq      = 1'b0;
    b_run      = 1'b0;
    b_count    = '0;
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_cnt"}, bus_a.count, m_count);
    check_eq({tag, "_run"}, bus_a.running, (m_state == MRun));
    check_eq({tag, "_irq"}, bus_a.irq, m_irq);
  endtask

  // Single-cycle control pulse on A (start/stop/irq_clear) or start on B.
  task automatic pulse(input bit s, input bit p, input bit clr, input bit on_b, input string tag);
    @(negedge clk);
    if (on_b) bus_b.start = s;
    else      bus_a.start = s;
    bus_a.stop      = p;
    bus_a.irq_clear = clr;
    if (p) begin
      m_state = MIdle;
    end else if (s && !on_b) begin
      m_state    = MRun;
      m_count    = '0;
      m_period   = bus_a.period;
      m_periodic = bus_a.periodic;
    end
    if (s && on_b) begin
      b_run   = 1'b1;
      b_count = '0;
    end
    if (clr) m_irq = 1'b0;
    @(negedge clk);
    bus_a.start     = 1'b0;
    bus_b.start     = 1'b0;
    bus_a.stop      = 1'b0;
    bus_a.irq_clear = 1'b0;
    check_status(tag);
  endtask

  // One rising edge of tick_clk_in; optional irq_clear on the edge where the count updates.
  task automatic do_tick(input bit clr, input string tag);
    exp_t e;
    bit   mt;
    @(negedge clk);
    tick_clk_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    if (clr) bus_a.irq_clear = 1'b1;
    mt = 1'b0;
    if (m_state == MRun) begin
      if (m_period != 0 && m_count == m_period - 32'd1) begin
        mt = 1'b1;
        m_matches++;
        if (m_periodic) begin
          m_count  = '0;
          m_period = bus_a.period;
        end else begin
          m_count = m_period;
          m_state = MDone;
        end
      end else begin
        m_count = m_count + 32'd1;
      end
    end
    if (mt) m_irq = 1'b1;
    else if (clr) m_irq = 1'b0;
    if (b_run) b_count = b_count + 4'd1;
    sb.push_back('{cnt: m_count, mt: mt, irq: m_irq, run: (m_state == MRun), cnt_b: b_count});
    @(posedge clk);
    @(negedge clk);
    bus_a.irq_clear = 1'b0;
    e = sb.pop_front();
    check_eq({tag, "_cnt"},   bus_a.count,   e.cnt);
    check_eq({tag, "_match"}, bus_a.match,   e.mt);
    check_eq({tag, "_irq"},   bus_a.irq,     e.irq);
    check_eq({tag, "_run"},   bus_a.running, e.run);
    check_eq({tag, "_cnt_b"}, bus_b.count,   e.cnt_b);
    check_eq({tag, "_mt_b"},  bus_b.match,   1'b0);
    @(negedge clk);
    tick_clk_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.periodic = 1'b0;
    bus_a.period = '0;  bus_a.irq_clear = 1'b0;
    bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.periodic = 1'b0;
    bus_b.period = '0;  bus_b.irq_clear = 1'b0;
    m_matches = 0;
    model_reset();

    // Reset with a stale high tick input: the resulting tick lands in IDLE.
    tick_clk_in = 1'b1;
    repeat (3) @(negedge clk);
    check_status("rst");
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_status("rst_hold");
    end
    tick_clk_in = 1'b0;
    repeat (4) @(negedge clk);

    // One-shot, period 3.
    bus_a.period   = 32'd3;
    bus_a.periodic = 1'b0;
    pulse(1'b1, 1'b0, 1'b0, 1'b0, "os_start");
    for (int i = 0; i < 8; i++) do_tick(1'b0, "os");
    check_eq("os_matches", match_seen_a, m_matches);

    // Periodic, period 2; clear coincides with the third match.
    pulse(1'b0, 1'b0, 1'b1, 1'b0, "pre_clr");
    bus_a.period   = 32'd2;
    bus_a.periodic = 1'b1;
    pulse(1'b1, 1'b0, 1'b0, 1'b0, "per_start");
    for (int i = 0; i < 5; i++) do_tick(1'b0, "per");
    do_tick(1'b1, "per_clr");
    check_eq("per_matches", match_seen_a, m_matches);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, "clr_alone");

    // Period change mid-run only takes effect at the reload.
    bus_a.period   = 32'd5;
    bus_a.periodic = 1'b1;
    pulse(1'b1, 1'b0, 1'b0, 1'b0, "chg_start");
    do_tick(1'b0, "chg");
    do_tick(1'b0, "chg");
    bus_a.period = 32'd1;
    for (int i = 0; i < 3; i++) do_tick(1'b0, "chg_late");
    check_eq("chg_matches", match_seen_a, m_matches);
    pulse(1'b1, 1'b1, 1'b0, 1'b0, "start_stop");

    // Zero period on the 4-bit instance: free-run and wrap, never match.
    bus_b.period   = 4'd0;
    bus_b.periodic = 1'b1;
    pulse(1'b1, 1'b0, 1'b0, 1'b1, "wrap_start");
    for (int i = 0; i < 17; i++) do_tick(1'b0, "wrap");
    check_eq("wrap_cnt_final", bus_b.count, 4'd1);
    check_eq("wrap_irq_b", bus_b.irq, 1'b0);
    check_eq("wrap_matches_b", match_seen_b, 0);

    // Reset mid-run at count 7 with irq still set.
    bus_a.period   = 32'd20;
    bus_a.periodic = 1'b0;
    pulse(1'b1, 1'b0, 1'b0, 1'b0, "mid_start");
    for (int i = 0; i < 7; i++) do_tick(1'b0, "mid");
    check_eq("mid_pre_cnt", bus_a.count, 32'd7);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_status("mid_rst");
    check_eq("mid_rst_cnt_b", bus_b.count, 4'd0);
    @(negedge clk);
    reset_n = 1'b1;
    do_tick(1'b0, "post_rst");
    do_tick(1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
